// File: rtl/adder_tree_pipe_if.sv
// Stream bundle for adder_tree_pipe.
//   in_valid/in_ready/in_data/in_last : input vector stream (N_IN lanes of WIDTH bits)
//   out_valid/out_ready/out_sum/out_ovf : result stream (OUT_W-bit sum plus overflow flag)
// master: the side that produces vectors and consumes results (bench / upstream logic)
// slave : the adder tree itself
interface adder_tree_pipe_if #(
  parameter int WIDTH = 13,
  parameter int N_IN  = 8,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_sum;
  logic                    out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree with optional frame accumulation.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : adder_tree_pipe_if.slave -- input vector stream and result stream
// Stage 0 registers the input vector; stages 1..LOG2N each add adjacent lane
// pairs, growing one bit per level so nothing is truncated. With ACC_EN=0 the
// last tree level is the output. With ACC_EN=1 an extra accumulator stage sums
// tree results over a frame and emits one result per in_last-marked vector.
// The whole pipe moves only when the output slot is empty or being taken.
module adder_tree_pipe #(
  parameter int WIDTH    = 13,
  parameter int N_IN     = 8,
  parameter int SIGNED   = 0,
  parameter int ACC_EN   = 0,
  parameter int ACC_BITS = 0,
  localparam int LOG2N   = $clog2(N_IN),
  localparam int SUM_W   = WIDTH + LOG2N,
  localparam int OUT_W   = WIDTH + LOG2N + ACC_BITS
) (
  input logic              clk,
  input logic              rst,
  adder_tree_pipe_if.slave bus
);

  localparam int L = LOG2N;

  // Extend a full tree sum to the output width according to SIGNED.
  function automatic logic [OUT_W-1:0] ext_out(input logic [SUM_W-1:0] d);
    logic [OUT_W-1:0] r;
    r = {OUT_W{(SIGNED != 0) && d[SUM_W-1]}};
    r[SUM_W-1:0] = d;
    return r;
  endfunction

  // Wrapping accumulator add; MSB of the result is the overflow indication
  // (carry-out when unsigned, two's complement overflow when signed).
  function automatic logic [OUT_W:0] acc_add(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    logic [OUT_W:0] s;
    logic           ov;
    s = {1'b0, a} + {1'b0, b};
    if (SIGNED != 0)
      ov = (a[OUT_W-1] == b[OUT_W-1]) && (s[OUT_W-1] != a[OUT_W-1]);
    else
      ov = s[OUT_W];
    return {ov, s[OUT_W-1:0]};
  endfunction

  logic                  advance;
  logic [L:0]            vld;
  logic [L:0]            lst;
  logic [N_IN*WIDTH-1:0] data_p0;
  logic [SUM_W-1:0]      sum_final;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Valid/last shift register: bit j belongs to stage j. A bubble enters as
  // vld[0]=0 whenever the pipe advances without a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else if (advance) begin
      vld <= {vld[L-1:0], bus.in_valid};
      lst <= {lst[L-1:0], bus.in_valid && bus.in_last};
    end
  end

  // ---- stage 0: input register ----
  always_ff @(posedge clk) begin
    if (advance && bus.in_valid) data_p0 <= bus.in_data;
  end

  // ---- stages 1..L: tree levels ----
  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int PW = WIDTH + j - 1;
    localparam int LW = WIDTH + j;
    localparam int NL = N_IN >> j;

    logic [2*NL*PW-1:0] prev;
    logic [NL*LW-1:0]   nxt;
    logic [NL*LW-1:0]   sum;

    if (j == 1) begin : g_src0
      assign prev = data_p0;
    end else begin : g_srcn
      assign prev = g_lvl[j-1].sum;
    end

    always_comb begin
      logic [PW-1:0] a;
      logic [PW-1:0] b;
      nxt = '0;
      a   = '0;
      b   = '0;
      for (int k = 0; k < NL; k++) begin
        a = prev[(2*k)*PW +: PW];
        b = prev[(2*k+1)*PW +: PW];
        nxt[k*LW +: LW] = {(SIGNED != 0) && a[PW-1], a} + {(SIGNED != 0) && b[PW-1], b};
      end
    end

    // The last level doubles as the output register in per-vector mode,
    // so only there does it need a reset value.
    if (j == L && ACC_EN == 0) begin : g_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          sum <= '0;
        else if (advance) sum <= nxt;
      end
    end else begin : g_nrst
      always_ff @(posedge clk) begin
        if (advance) sum <= nxt;
      end
    end
  end

  assign sum_final = g_lvl[L].sum;

  if (ACC_EN == 0) begin : g_direct
    logic unused_lst;
    assign unused_lst    = lst[L];
    assign bus.out_valid = vld[L];
    assign bus.out_sum   = ext_out(sum_final);
    assign bus.out_ovf   = 1'b0;
  end else begin : g_acc
    logic [OUT_W-1:0] acc_p;
    logic             acc_ovf_p;
    logic             out_vld_p;
    logic [OUT_W-1:0] out_sum_p;
    logic             out_ovf_p;
    logic [OUT_W:0]   add;

    assign add = acc_add(acc_p, ext_out(sum_final));

    // ---- stage L+1: frame accumulator / output register ----
    // On a last-marked sum the total goes to the output and the accumulator
    // clears in the same edge, so the next vector starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_p     <= '0;
        acc_ovf_p <= 1'b0;
        out_vld_p <= 1'b0;
        out_sum_p <= '0;
        out_ovf_p <= 1'b0;
      end else if (advance) begin
        if (vld[L] && lst[L]) begin
          out_sum_p <= add[OUT_W-1:0];
          out_ovf_p <= acc_ovf_p | add[OUT_W];
          out_vld_p <= 1'b1;
          acc_p     <= '0;
          acc_ovf_p <= 1'b0;
        end else begin
          out_vld_p <= 1'b0;
          if (vld[L]) begin
            acc_p     <= add[OUT_W-1:0];
            acc_ovf_p <= acc_ovf_p | add[OUT_W];
          end
        end
      end
    end

    assign bus.out_valid = out_vld_p;
    assign bus.out_sum   = out_sum_p;
    assign bus.out_ovf   = out_ovf_p;
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: three instances (unsigned per-vector,
// signed per-vector, unsigned frame-accumulate) share a clock, reset and a
// common stimulus bus routed to the selected instance.
module tb_adder_tree_pipe;

  localparam int W  = 13;
  localparam int N  = 8;
  localparam int OW = 16;

  logic clk;
  logic rst;
  int   sel;
  logic in_valid_c;
  logic [N*W-1:0] in_data_c;
  logic in_last_c;
  logic out_ready_c;
  logic in_ready_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  int   acc_m = 0;
  bit   ovf_m = 0;

  adder_tree_pipe_if #(.WIDTH(W), .N_IN(N), .OUT_W(OW)) ifa ();
  adder_tree_pipe_if #(.WIDTH(W), .N_IN(N), .OUT_W(OW)) ifb ();
  adder_tree_pipe_if #(.WIDTH(W), .N_IN(N), .OUT_W(OW)) ifc ();

  adder_tree_pipe #(.WIDTH(W), .N_IN(N), .SIGNED(0), .ACC_EN(0), .ACC_BITS(0))
    u_uns (.clk(clk), .rst(rst), .bus(ifa.slave));
  adder_tree_pipe #(.WIDTH(W), .N_IN(N), .SIGNED(1), .ACC_EN(0), .ACC_BITS(0))
    u_sgn (.clk(clk), .rst(rst), .bus(ifb.slave));
  adder_tree_pipe #(.WIDTH(W), .N_IN(N), .SIGNED(0), .ACC_EN(1), .ACC_BITS(0))
    u_acc (.clk(clk), .rst(rst), .bus(ifc.slave));

  assign ifa.in_valid  = in_valid_c && (sel == 0);
  assign ifb.in_valid  = in_valid_c && (sel == 1);
  assign ifc.in_valid  = in_valid_c && (sel == 2);
  assign ifa.in_data   = in_data_c;
  assign ifb.in_data   = in_data_c;
  assign ifc.in_data   = in_data_c;
  assign ifa.in_last   = in_last_c;
  assign ifb.in_last   = in_last_c;
  assign ifc.in_last   = in_last_c;
  assign ifa.out_ready = out_ready_c;
  assign ifb.out_ready = out_ready_c;
  assign ifc.out_ready = out_ready_c;
  assign in_ready_c = (sel == 0) ? ifa.in_ready : (sel == 1) ? ifb.in_ready : ifc.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tree_sum(input logic [N*W-1:0] d, input bit sgn);
    int s;
    logic [W-1:0] v;
    s = 0;
    for (int i = 0; i < N; i++) begin
      v = d[i*W +: W];
      if (sgn && v[W-1]) s += int'(v) - (1 << W);
      else               s += int'(v);
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] alt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [N*W-1:0] lane0(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input int s, input logic [N*W-1:0] d, input logic last);
    int ts;
    int guard;
    logic [15:0] t16;
    ts  = tree_sum(d, s == 1);
    t16 = ts[15:0];
    if (s == 2) begin
      acc_m += ts;
      if (acc_m >= 65536) begin
        ovf_m = 1;
        acc_m -= 65536;
      end
      if (last) begin
        q2.push_back({ovf_m, acc_m[15:0]});
        acc_m = 0;
        ovf_m = 0;
      end
    end else if (s == 1) q1.push_back({1'b0, t16});
    else                 q0.push_back({1'b0, t16});
    sel = s; in_data_c = d; in_last_c = last; in_valid_c = 1'b1;
    guard = 0;
    #1;
    while (!in_ready_c && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", {31'd0, in_ready_c}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_c = 1'b0;
    in_last_c  = 1'b0;
  endtask

  always @(negedge clk) begin
    #3;
    if (ifa.out_valid && ifa.out_ready) begin
      chk("uns_expected_pending", {31'd0, q0.size() != 0}, 32'd1);
      if (q0.size() != 0) chk("uns_out", {15'd0, ifa.out_ovf, ifa.out_sum}, {15'd0, q0.pop_front()});
    end
    if (ifb.out_valid && ifb.out_ready) begin
      chk("sgn_expected_pending", {31'd0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) chk("sgn_out", {15'd0, ifb.out_ovf, ifb.out_sum}, {15'd0, q1.pop_front()});
    end
    if (ifc.out_valid && ifc.out_ready) begin
      chk("acc_expected_pending", {31'd0, q2.size() != 0}, 32'd1);
      if (q2.size() != 0) chk("acc_out", {15'd0, ifc.out_ovf, ifc.out_sum}, {15'd0, q2.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    rst = 1'b1; sel = 0; in_valid_c = 1'b0; in_data_c = '0; in_last_c = 1'b0; out_ready_c = 1'b1;
    #2;
    chk("rst_uns_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_uns_sum",   {16'd0, ifa.out_sum},   32'd0);
    chk("rst_acc_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_acc_sum",   {16'd0, ifc.out_sum},   32'd0);
    chk("rst_acc_ovf",   {31'd0, ifc.out_ovf},   32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_uns", {31'd0, ifa.in_ready}, 32'd1);
    chk("post_rst_ready_acc", {31'd0, ifc.in_ready}, 32'd1);

    // All-ones unsigned vector: result exactly four cycles after the transfer.
    send(0, fill(13'h1FFF), 1'b0);
    #2 chk("lat_c1", {31'd0, ifa.out_valid}, 32'd0);
    @(negedge clk); #2 chk("lat_c2", {31'd0, ifa.out_valid}, 32'd0);
    @(negedge clk); #2 chk("lat_c3", {31'd0, ifa.out_valid}, 32'd0);
    @(negedge clk); #2 chk("lat_c4", {31'd0, ifa.out_valid}, 32'd1);
    chk("lat_sum", {16'd0, ifa.out_sum}, 32'd65528);
    @(negedge clk); #2 chk("lat_single", {31'd0, ifa.out_valid}, 32'd0);
    @(negedge clk);

    // Signed lanes.
    send(1, fill(13'h1FFF), 1'b0);
    send(1, alt(13'd4095, 13'h1000), 1'b0);
    repeat (8) @(negedge clk);

    // Back-to-back stream with a three-cycle output stall.
    fork
      begin
        for (int k = 1; k <= 6; k++) send(0, lane0(k[W-1:0]), 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready_c = 1'b0;
        #2;
        held = ifa.out_sum;
        chk("bp_valid", {31'd0, ifa.out_valid}, 32'd1);
        chk("bp_held_val", {16'd0, held}, 32'd2);
        chk("bp_in_ready", {31'd0, ifa.in_ready}, 32'd0);
        repeat (2) begin
          @(negedge clk); #2;
          chk("bp_in_ready", {31'd0, ifa.in_ready}, 32'd0);
          chk("bp_hold", {16'd0, ifa.out_sum}, {16'd0, held});
        end
        @(negedge clk);
        out_ready_c = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("bp_drained", q0.size(), 32'd0);

    // Frame accumulation.
    send(2, lane0(13'd100), 1'b0);
    send(2, lane0(13'd100), 1'b0);
    send(2, lane0(13'd100), 1'b1);
    send(2, lane0(13'd5),   1'b1);
    repeat (8) @(negedge clk);
    send(2, fill(13'h1FFF), 1'b0);
    send(2, fill(13'h1FFF), 1'b1);
    send(2, lane0(13'd7),   1'b1);
    repeat (10) @(negedge clk);
    chk("acc_drained", q2.size(), 32'd0);

    // Reset with a partial frame accumulated and three vectors in flight.
    send(2, lane0(13'd50), 1'b0);
    send(2, lane0(13'd50), 1'b0);
    repeat (6) @(negedge clk);
    send(2, lane0(13'd10), 1'b0);
    send(2, lane0(13'd10), 1'b0);
    send(2, lane0(13'd10), 1'b1);
    q2.delete();
    acc_m = 0;
    ovf_m = 0;
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("mid_rst_sum",   {16'd0, ifc.out_sum},   32'd0);
    chk("mid_rst_ovf",   {31'd0, ifc.out_ovf},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(2, lane0(13'd9), 1'b0);
    send(2, lane0(13'd4), 1'b1);
    repeat (10) @(negedge clk);
    chk("final_q_uns", q0.size(), 32'd0);
    chk("final_q_sgn", q1.size(), 32'd0);
    chk("final_q_acc", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
